// File: rtl/counter_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : counter_cmd_pkg
// Brief    : Shared types for the counter command sequencer (opcodes and
//            sequencer states).
// Revision : 1.0 - initial release
// ============================================================================
package counter_cmd_pkg;

    // Command opcodes as carried on cmd_op_i
    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_LOAD = 2'b01,
        OP_RUN  = 2'b10,
        OP_HOLD = 2'b11
    } cmd_op_e;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10,
        ST_HOLD = 2'b11
    } seq_state_e;

endpackage : counter_cmd_pkg
`default_nettype wire

// File: rtl/counter_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : counter_cmd_seq
// Brief    : Command sequencer driving a counter's load/enable/data controls.
//            Accepts NOP/LOAD/RUN/HOLD over valid/ready, emits cycle-exact
//            control patterns and a one-cycle done pulse per command.
// Revision : 1.0 - initial release
// ============================================================================
module counter_cmd_seq
    import counter_cmd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [1:0]       cmd_op_i,
    input  logic [WIDTH-1:0] cmd_arg_i,
    input  logic             abort_i,
    output logic             load_o,
    output logic             enable_o,
    output logic [WIDTH-1:0] data_o,
    output logic             busy_o,
    output logic             done_o
);

    seq_state_e       r_state;
    logic [WIDTH-1:0] r_remaining;
    logic             r_load;
    logic             r_enable;
    logic [WIDTH-1:0] r_data;
    logic             r_busy;
    logic             r_done;

    cmd_op_e          w_op;
    logic             w_accept;
    logic             w_arg_zero;

    // Ready is held low while in reset so every output reads 0 during reset
    assign cmd_ready_o = rst_ni && (r_state == ST_IDLE) && !abort_i;
    assign w_accept    = cmd_valid_i && cmd_ready_o;
    assign w_op        = cmd_op_e'(cmd_op_i);
    assign w_arg_zero  = (cmd_arg_i == '0);

    assign load_o      = r_load;
    assign enable_o    = r_enable;
    assign data_o      = r_data;
    assign busy_o      = r_busy;
    assign done_o      = r_done;

    // Sequencer FSM: state, remaining-count down-counter and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_load      <= 1'b0;
            r_enable    <= 1'b0;
            r_data      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // done is a single-cycle pulse unless a branch below re-asserts it
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        case (w_op)
                            OP_LOAD: begin
                                r_state <= ST_LOAD;
                                r_load  <= 1'b1;
                                r_data  <= cmd_arg_i;
                                r_busy  <= 1'b1;
                            end
                            OP_RUN, OP_HOLD: begin
                                if (w_arg_zero) begin
                                    // zero-length run/hold completes immediately
                                    r_done <= 1'b1;
                                end else begin
                                    r_state     <= (w_op == OP_RUN) ? ST_RUN : ST_HOLD;
                                    r_remaining <= cmd_arg_i;
                                    r_enable    <= (w_op == OP_RUN);
                                    r_busy      <= 1'b1;
                                end
                            end
                            default: begin
                                r_done <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_LOAD: begin
                    // single load cycle; abort suppresses only the done pulse
                    r_state <= ST_IDLE;
                    r_load  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= !abort_i;
                end
                ST_RUN, ST_HOLD: begin
                    if (abort_i || (r_remaining == WIDTH'(1))) begin
                        r_state     <= ST_IDLE;
                        r_remaining <= '0;
                        r_enable    <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= !abort_i;
                    end else begin
                        r_remaining <= r_remaining - WIDTH'(1);
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_load   <= 1'b0;
                    r_enable <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule : counter_cmd_seq
`default_nettype wire

// File: tb/tb_counter_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_cmd_seq
// Brief    : Directed self-checking bench for counter_cmd_seq, with a small
//            behavioural counter model on the load/enable/data outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_cmd_seq;

    localparam logic [1:0] C_NOP  = 2'b00;
    localparam logic [1:0] C_LOAD = 2'b01;
    localparam logic [1:0] C_RUN  = 2'b10;
    localparam logic [1:0] C_HOLD = 2'b11;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_arg;
    logic       abort;
    logic       load_o;
    logic       enable_o;
    logic [7:0] data_o;
    logic       busy_o;
    logic       done_o;

    logic [7:0] cnt;
    logic [7:0] prev_cnt;
    logic [7:0] log_q[$];
    logic       log_en;
    int         done_cnt;
    int         checks;
    int         errors;

    counter_cmd_seq #(.WIDTH(8)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_op_i    (cmd_op),
        .cmd_arg_i   (cmd_arg),
        .abort_i     (abort),
        .load_o      (load_o),
        .enable_o    (enable_o),
        .data_o      (data_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream counter model: load wins, otherwise increment when enabled
    initial cnt = 8'h00;
    always @(posedge clk) begin
        if (load_o)        cnt <= data_o;
        else if (enable_o) cnt <= cnt + 8'h01;
    end

    // Done pulse tally, counter-value change log, and load/enable exclusivity
    initial begin
        done_cnt = 0;
        prev_cnt = 8'h00;
        log_en   = 1'b0;
    end
    always @(negedge clk) begin
        if (done_o) done_cnt++;
        if (log_en && (cnt !== prev_cnt)) log_q.push_back(cnt);
        prev_cnt = cnt;
        if (rst_n) begin
            checks++;
            if (load_o && enable_o) begin
                errors++;
                $display("FAIL excl: load_o=%b enable_o=%b, required not both high", load_o, enable_o);
            end
        end
    end

    // Issue one command at the coming edge and measure it until done (or timeout)
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] arg,
                           output int n_en, output int n_ld, output int n_busy,
                           output int n_nrdy, output int done_idx, output logic [7:0] ld_data);
        n_en = 0; n_ld = 0; n_busy = 0; n_nrdy = 0; done_idx = -1; ld_data = 8'h00;
        cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
        @(posedge clk);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) cmd_valid = 1'b0;
            if (enable_o)   n_en++;
            if (load_o)     begin n_ld++; ld_data = data_o; end
            if (busy_o)     n_busy++;
            if (!cmd_ready) n_nrdy++;
            if (done_o) begin done_idx = i; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = C_NOP; cmd_arg = 8'h00; abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({cmd_ready, load_o, enable_o, busy_o, done_o, data_o} !== 13'h0) begin
                errors++;
                $display("FAIL reset_outs: got rdy=%b ld=%b en=%b busy=%b done=%b data=%h, required all 0",
                         cmd_ready, load_o, enable_o, busy_o, done_o, data_o);
            end
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got rdy=%b busy=%b, required rdy=1 busy=0", cmd_ready, busy_o);
        end
        @(negedge clk); #1;
    endtask

    task automatic test_load();
        int n_en, n_ld, n_busy, n_nrdy, idx, snap;
        logic [7:0] ld;
        snap = done_cnt;
        run_cmd(C_LOAD, 8'hA5, n_en, n_ld, n_busy, n_nrdy, idx, ld);
        checks++;
        if (n_ld !== 1 || ld !== 8'hA5 || n_en !== 0) begin
            errors++;
            $display("FAIL load_pulse: got loads=%0d data=%h en=%0d, required loads=1 data=a5 en=0", n_ld, ld, n_en);
        end
        checks++;
        if (idx !== 1 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_done: got done_idx=%0d rdy=%b, required done_idx=1 rdy=1", idx, cmd_ready);
        end
        checks++;
        if (cnt !== 8'hA5) begin
            errors++;
            $display("FAIL load_count: got %h, required a5", cnt);
        end
        @(negedge clk); #1;
        checks++;
        if (done_o !== 1'b0 || (done_cnt - snap) !== 1) begin
            errors++;
            $display("FAIL load_done_once: got done=%b pulses=%0d, required done=0 pulses=1", done_o, done_cnt - snap);
        end
    endtask

    task automatic test_load_run();
        int n_en, n_ld, n_busy, n_nrdy, idx, snap;
        logic [7:0] ld;
        snap = done_cnt;
        run_cmd(C_LOAD, 8'h10, n_en, n_ld, n_busy, n_nrdy, idx, ld);
        checks++;
        if (idx !== 1 || cnt !== 8'h10) begin
            errors++;
            $display("FAIL lr_load: got done_idx=%0d count=%h, required 1 and 10", idx, cnt);
        end
        #1;
        run_cmd(C_RUN, 8'd3, n_en, n_ld, n_busy, n_nrdy, idx, ld);
        checks++;
        if (n_en !== 3 || n_ld !== 0 || n_busy !== 3) begin
            errors++;
            $display("FAIL lr_run_en: got en=%0d ld=%0d busy=%0d, required 3 0 3", n_en, n_ld, n_busy);
        end
        checks++;
        if (idx !== 3 || cnt !== 8'h13) begin
            errors++;
            $display("FAIL lr_run_done: got done_idx=%0d count=%h, required 3 and 13", idx, cnt);
        end
        @(negedge clk); #1;
        checks++;
        if ((done_cnt - snap) !== 2) begin
            errors++;
            $display("FAIL lr_pulses: got %0d, required 2", done_cnt - snap);
        end
    endtask

    task automatic test_zero_len();
        logic [1:0] ops [3];
        int n_en, n_ld, n_busy, n_nrdy, idx, snap;
        logic [7:0] ld;
        ops[0] = C_RUN; ops[1] = C_HOLD; ops[2] = C_NOP;
        snap = done_cnt;
        for (int k = 0; k < 3; k++) begin
            run_cmd(ops[k], 8'h00, n_en, n_ld, n_busy, n_nrdy, idx, ld);
            checks++;
            if (idx !== 0 || n_en !== 0 || n_ld !== 0 || n_busy !== 0 || n_nrdy !== 0) begin
                errors++;
                $display("FAIL zero_len op=%0d: got done_idx=%0d en=%0d ld=%0d busy=%0d notready=%0d, required 0 0 0 0 0",
                         ops[k], idx, n_en, n_ld, n_busy, n_nrdy);
            end
            #1;
        end
        @(negedge clk); #1;
        checks++;
        if ((done_cnt - snap) !== 3) begin
            errors++;
            $display("FAIL zero_pulses: got %0d, required 3", done_cnt - snap);
        end
    endtask

    task automatic test_abort();
        int n_en, n_ld, n_busy, n_nrdy, idx, snap;
        logic [7:0] ld;
        run_cmd(C_LOAD, 8'h00, n_en, n_ld, n_busy, n_nrdy, idx, ld);
        #1;
        snap = done_cnt;
        n_en = 0;
        cmd_valid = 1'b1; cmd_op = C_RUN; cmd_arg = 8'd10;
        @(posedge clk);
        // abort raised in the 4th enable cycle is taken at the edge that would open the 5th
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) cmd_valid = 1'b0;
            if (enable_o) n_en++;
            if (i == 3) abort = 1'b1;
        end
        @(negedge clk);
        abort = 1'b0;
        #1;
        checks++;
        if (n_en !== 4 || enable_o !== 1'b0 || busy_o !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_state: got en_cycles=%0d en=%b busy=%b rdy=%b, required 4 0 0 1",
                     n_en, enable_o, busy_o, cmd_ready);
        end
        checks++;
        if (cnt !== 8'h04) begin
            errors++;
            $display("FAIL abort_count: got %h, required 04", cnt);
        end
        @(negedge clk); @(negedge clk); #1;
        checks++;
        if (done_cnt !== snap) begin
            errors++;
            $display("FAIL abort_nodone: got %0d pulses, required 0", done_cnt - snap);
        end
        // abort while idle blocks acceptance of a NOP
        abort = 1'b1; cmd_valid = 1'b1; cmd_op = C_NOP; cmd_arg = 8'h00;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle_rdy: got %b, required 0", cmd_ready);
        end
        @(negedge clk); #1;
        checks++;
        if (done_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle_done: got %b, required 0", done_o);
        end
        abort = 1'b0; cmd_valid = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [1:0] ops [3];
        logic [7:0] args [3];
        logic [7:0] exp_log [4];
        int k;
        logic seen;
        ops[0] = C_LOAD; ops[1] = C_HOLD; ops[2] = C_RUN;
        args[0] = 8'hFE; args[1] = 8'd2;  args[2] = 8'd3;
        exp_log[0] = 8'hFE; exp_log[1] = 8'hFF; exp_log[2] = 8'h00; exp_log[3] = 8'h01;
        log_q.delete();
        log_en = 1'b1;
        k = 0;
        cmd_valid = 1'b1; cmd_op = ops[0]; cmd_arg = args[0];
        for (int c = 0; c < 40 && k < 3; c++) begin
            if (cmd_ready) begin
                if (k > 0) begin
                    checks++;
                    if (done_o !== 1'b1) begin
                        errors++;
                        $display("FAIL b2b_accept_in_done cmd=%0d: got done=%b, required 1", k, done_o);
                    end
                end
                k++;
            end
            @(negedge clk); #1;
            if (k < 3) begin cmd_op = ops[k]; cmd_arg = args[k]; end
            else cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        checks++;
        if (k !== 3) begin
            errors++;
            $display("FAIL b2b_timeout: got %0d accepted, required 3", k);
        end
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done_o) begin seen = 1'b1; break; end
            @(negedge clk); #1;
        end
        checks++;
        if (seen !== 1'b1) begin
            errors++;
            $display("FAIL b2b_run_done: got no done, required done");
        end
        log_en = 1'b0;
        checks++;
        if (log_q.size() !== 4) begin
            errors++;
            $display("FAIL b2b_log_len: got %0d values, required 4", log_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (log_q[i] !== exp_log[i]) begin
                    errors++;
                    $display("FAIL b2b_count[%0d]: got %h, required %h", i, log_q[i], exp_log[i]);
                end
            end
        end
        @(negedge clk); #1;
    endtask

    task automatic test_mid_reset();
        int snap;
        cmd_valid = 1'b1; cmd_op = C_RUN; cmd_arg = 8'd5;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        #2;
        checks++;
        if (enable_o !== 1'b1 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_run_active: got en=%b busy=%b, required 1 1", enable_o, busy_o);
        end
        snap = done_cnt;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, load_o, enable_o, busy_o, done_o, data_o} !== 13'h0) begin
            errors++;
            $display("FAIL mid_reset_outs: got rdy=%b ld=%b en=%b busy=%b done=%b data=%h, required all 0",
                     cmd_ready, load_o, enable_o, busy_o, done_o, data_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) @(negedge clk);
        #1;
        checks++;
        if (done_cnt !== snap || cmd_ready !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_after: got pulses=%0d rdy=%b busy=%b, required 0 1 0",
                     done_cnt - snap, cmd_ready, busy_o);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_load();
        test_load_run();
        test_zero_len();
        test_abort();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_counter_cmd_seq
`default_nettype wire
